// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the float scheduler: op codes, FSM states and
// bfloat16-style field helpers (sign bit 15, exponent 14:7, mantissa 6:0).
package fpu_sched_pkg;
  localparam logic [2:0] FOP_ADD = 3'd0;
  localparam logic [2:0] FOP_SUB = 3'd1;
  localparam logic [2:0] FOP_MUL = 3'd2;
  localparam logic [2:0] FOP_DIV = 3'd3;
  localparam logic [2:0] FOP_SLT = 3'd4;
  localparam logic [2:0] FOP_I2F = 3'd5;
  localparam logic [2:0] FOP_F2I = 3'd6;
  localparam logic [2:0] FOP_RSV = 3'd7;

  localparam int FSIGN = 15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_RESP} state_t;

  function automatic logic [15:0] fneg(input logic [15:0] x);
    return {~x[FSIGN], x[FSIGN-1:0]};
  endfunction
endpackage

// File: rtl/fpu_sched_if.sv
// Request/response bundle between two requesters and the shared float unit.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// source holds valid and payload stable until then, and ready may depend on valid.
interface fpu_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_data;
  logic        resp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/fpu_sched_datapath.sv
// Combinational float datapath: one instance of each float primitive, muxed by
// op and step. Arithmetic truncates, ignores NaN/Inf and treats exponent 0 as zero.
module fpu_datapath
  import fpu_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic        step,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);
  logic [15:0] add_y, mul_y, rcp_y, i2f_y, f2i_y;
  logic        slt_y;

  fadd   u_fadd   (.a(a), .b(b), .y(add_y));
  fmul   u_fmul   (.a(a), .b(b), .y(mul_y));
  frecip u_frecip (.b(b), .y(rcp_y));
  fslt   u_fslt   (.a(a), .b(b), .lt(slt_y));
  i2f    u_i2f    (.a(a), .y(i2f_y));
  f2i    u_f2i    (.a(a), .y(f2i_y));

  // Division is recip(b) on the first step, then a * recip(b) on the second.
  always_comb begin
    result = 16'h0000;
    case (op)
      FOP_ADD, FOP_SUB: result = add_y;
      FOP_MUL:          result = mul_y;
      FOP_DIV:          result = step ? mul_y : rcp_y;
      FOP_SLT:          result = {15'd0, slt_y};
      FOP_I2F:          result = i2f_y;
      FOP_F2I:          result = f2i_y;
      default:          result = 16'h0000;
    endcase
  end
endmodule

module fadd (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic [15:0] big, sml;
  logic [7:0]  mb, ms, ms_sh, diff, sh;
  logic [8:0]  sum;
  logic [3:0]  lz;
  logic [6:0]  norm;

  always_comb begin
    if (a[14:0] >= b[14:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    mb    = (big[14:7] == 8'd0) ? 8'd0 : {1'b1, big[6:0]};
    ms    = (sml[14:7] == 8'd0) ? 8'd0 : {1'b1, sml[6:0]};
    sh    = big[14:7] - sml[14:7];
    ms_sh = (sh > 8'd7) ? 8'd0 : (ms >> sh[2:0]);
    sum   = {1'b0, mb} + {1'b0, ms_sh};
    diff  = mb - ms_sh;
    lz    = 4'd0;
    for (int i = 0; i < 8; i++) if (diff[i]) lz = 4'(7 - i);
    norm  = 7'(diff << lz);
    y = 16'h0000;
    if (big[15] == sml[15]) begin
      if (sum[8])
        y = (big[14:7] >= 8'hFE) ? {big[15], 8'hFE, 7'h7F} : {big[15], big[14:7] + 8'd1, sum[7:1]};
      else if (sum[7])
        y = {big[15], big[14:7], sum[6:0]};
    end else if (diff != 8'd0 && {1'b0, big[14:7]} > {5'd0, lz}) begin
      y = {big[15], big[14:7] - {4'd0, lz}, norm};
    end
  end
endmodule

module fmul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic [8:0] ph;
  logic [9:0] e;
  logic [6:0] m;

  always_comb begin
    ph = 9'(({8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]}) >> 7);
    e  = {2'b0, a[14:7]} + {2'b0, b[14:7]} + {9'd0, ph[8]};
    m  = ph[8] ? ph[7:1] : ph[6:0];
    y  = 16'h0000;
    if (a[14:7] != 8'd0 && b[14:7] != 8'd0) begin
      if (e > 10'd127 && e < 10'd382) y = {a[15] ^ b[15], 8'(e - 10'd127), m};
      else if (e >= 10'd382)          y = {a[15] ^ b[15], 8'hFE, 7'h7F};
    end
  end
endmodule

module frecip (
  input  logic [15:0] b,
  output logic [15:0] y
);
  // Inverse mantissa table; look(0) = 0 because 1/1.0 is an exact power of two.
  function automatic logic [6:0] look(input logic [6:0] m);
    if (m == 7'd0) return 7'd0;
    return 7'(16'd32768 / {8'd0, 1'b1, m});
  endfunction

  always_comb begin
    y = 16'h0000;
    if (b[14:7] != 8'd0) begin
      if (b[6:0] == 7'd0 && b[14:7] < 8'd254)
        y = {b[15], 8'd254 - b[14:7], 7'd0};
      else if (b[6:0] != 7'd0 && b[14:7] < 8'd253)
        y = {b[15], 8'd253 - b[14:7], look(b[6:0])};
    end
  end
endmodule

module fslt (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        lt
);
  logic [14:0] ma, mb;

  always_comb begin
    ma = (a[14:7] == 8'd0) ? 15'd0 : a[14:0];
    mb = (b[14:7] == 8'd0) ? 15'd0 : b[14:0];
    if (ma == 15'd0 && mb == 15'd0) lt = 1'b0;
    else if (a[15] != b[15])        lt = a[15];
    else if (a[15])                 lt = ma > mb;
    else                            lt = ma < mb;
  end
endmodule

module i2f (
  input  logic [15:0] a,
  output logic [15:0] y
);
  logic [15:0] mag;
  logic [3:0]  pos;
  logic [6:0]  mant;

  always_comb begin
    mag = a[15] ? (~a + 16'd1) : a;
    pos = 4'd0;
    for (int i = 0; i < 16; i++) if (mag[i]) pos = 4'(i);
    mant = 7'((mag << (4'd15 - pos)) >> 8);
    y = (mag == 16'd0) ? 16'h0000 : {a[15], 8'd127 + {4'd0, pos}, mant};
  end
endmodule

module f2i (
  input  logic [15:0] a,
  output logic [15:0] y
);
  logic [15:0] mag;
  logic [7:0]  sh;

  always_comb begin
    sh  = a[14:7] - 8'd127;
    mag = 16'd0;
    y   = 16'd0;
    if (a[14:7] >= 8'd142) begin
      y = a[15] ? 16'h8000 : 16'h7FFF;
    end else if (a[14:7] >= 8'd127) begin
      mag = (sh < 8'd7) ? ({8'd0, 1'b1, a[6:0]} >> (8'd7 - sh))
                        : ({8'd0, 1'b1, a[6:0]} << (sh - 8'd7));
      y = a[15] ? (~mag + 16'd1) : mag;
    end
  end
endmodule

// File: rtl/fpu_sched.sv
// Round-robin scheduler sharing one float datapath between two requesters;
// captures operands, sequences two-step divide and returns one response per op.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter bit RR_INIT = 1'b1,
  parameter bit DIV_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  fpu_sched_if.slave   bus,
  output logic         busy,
  output state_t       dbg_state
);
  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic        resp_err_q, resp_err_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d, resp_data_q, resp_data_d;
  logic [15:0] dp_result, sel_a, sel_b;
  logic [2:0]  sel_op;
  logic        gnt_valid, gnt_id, accept, op_err;

  fpu_datapath u_dp (
    .op     (op_q),
    .step   (state_q == S_EXEC2),
    .a      (a_q),
    .b      (b_q),
    .result (dp_result)
  );

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt_valid      = bus.req0_valid | bus.req1_valid;
    gnt_id         = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    bus.req0_ready = (state_q == S_IDLE) && gnt_valid && !gnt_id;
    bus.req1_ready = (state_q == S_IDLE) && gnt_valid && gnt_id;
    accept         = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
    sel_op         = gnt_id ? bus.req1_op : bus.req0_op;
    sel_a          = gnt_id ? bus.req1_a  : bus.req0_a;
    sel_b          = gnt_id ? bus.req1_b  : bus.req0_b;
    op_err         = (op_q == FOP_RSV) || (op_q == FOP_DIV && !DIV_EN);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d         = sel_op;
          a_d          = sel_a;
          b_d          = (sel_op == FOP_SUB) ? fneg(sel_b) : sel_b;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          state_d      = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (op_err) begin
          resp_data_d = 16'h0000;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end else if (op_q == FOP_DIV) begin
          // b is reused to hold recip(b) for the second step.
          b_d     = dp_result;
          state_d = S_EXEC2;
        end else begin
          resp_data_d = dp_result;
          resp_err_d  = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_EXEC2: begin
        resp_data_d = dp_result;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_err_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= RR_INIT;
      id_q         <= 1'b0;
      op_q         <= 3'd0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      resp_data_q  <= 16'h0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;
endmodule
